// File: rtl/uart_tx_buffer_if.sv
// rtl/uart_tx_buffer_if.sv - write, status and UART-side signals of the tx byte buffer
interface uart_tx_buffer_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  clr_ovf;
    logic [7:0]            tx_data;
    logic                  tx_send;
    logic                  tx_tip;

    modport master (
        output wr_en, wr_data, clr_ovf, tx_tip,
        input  full, empty, level, overflow, tx_data, tx_send
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_tip,
        output full, empty, level, overflow, tx_data, tx_send
    );
endinterface

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - byte FIFO draining one byte at a time into the UART send/TiP handshake
module uart_tx_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_buffer_if.slave  bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic [7:0]            r_tx_data;
    logic                  r_tx_send;
    state_t                r_state;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    // A pop in the same cycle never frees room for a push into a full FIFO.
    assign w_push  = bus.wr_en && !w_full;
    assign w_pop   = (r_state == IDLE) && !w_empty && !bus.tx_tip;

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.level    = r_count;
    assign bus.overflow = r_overflow;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_send  = r_tx_send;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
            // A dropped push outranks a simultaneous clear.
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tx_send <= 1'b0;
            r_tx_data <= 8'h00;
            r_rd_ptr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= r_mem[r_rd_ptr];
                        r_rd_ptr  <= r_rd_ptr + DEPTH_LOG2'(1);
                        r_tx_send <= 1'b1;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    if (bus.tx_tip) begin
                        r_tx_send <= 1'b0;
                        r_state   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_tip) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx_send <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - table vectors plus scoreboard bench for uart_tx_buffer
module tb_uart_tx_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_auto = 1'b0;
    logic tip_force = 1'b0;
    logic tip_model = 1'b0;

    int total = 0;
    int bad = 0;
    int recv_cnt = 0;
    logic saw_ff = 1'b0;
    logic mon_en = 1'b0;

    logic [7:0] exp_q[$];

    uart_tx_buffer_if #(.DEPTH_LOG2(4)) bus ();

    uart_tx_buffer #(.DEPTH_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.tx_tip = uart_auto ? tip_model : tip_force;

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [7:0] data;
        logic       clr;
        logic [4:0] lvl;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int b = 0;
        while ((exp_q.size() != 0 || bus.tx_send || bus.tx_tip) && b < budget) begin
            step();
            b++;
        end
        total++;
        if (b >= budget) begin
            bad++;
            $display("FAIL drain_timeout got=%0d cycles exp<%0d", b, budget);
        end
        repeat (3) step();
        chk("drain_level", 32'(bus.level), 32'd0);
        chk("drain_empty", 32'(bus.empty), 32'd1);
    endtask

    // UART model: TiP high for 10 cycles per frame, changed away from the edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (uart_auto && bus.tx_send && !tip_model) begin
                tip_model = 1'b1;
                repeat (10) @(posedge clk);
                #2;
                tip_model = 1'b0;
            end
        end
    end

    // Scoreboard: pushes recorded before the edge that accepts them, pops checked after.
    initial begin
        logic prev_rst  = 1'b1;
        logic prev_send = 1'b0;
        logic prev_tip  = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (prev_rst) exp_q.delete();
            if (mon_en) begin
                if (bus.tx_send && !prev_send) begin
                    chk("start_tip_low", 32'(prev_tip), 32'd0);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_send got=%02h exp=none", bus.tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data_order", 32'(bus.tx_data), 32'(e));
                        recv_cnt++;
                        if (bus.tx_data == 8'hFF) saw_ff = 1'b1;
                    end
                end
                if (bus.tx_send && prev_send) chk("tx_data_stable", 32'(bus.tx_data), 32'(prev_data));
                chk("level_track", 32'(bus.level), 32'(exp_q.size()));
            end
            if (!rst && bus.wr_en && exp_q.size() < 16) exp_q.push_back(bus.wr_data);
            prev_rst  = rst;
            prev_send = bus.tx_send;
            prev_tip  = bus.tx_tip;
            prev_data = bus.tx_data;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int b;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.clr_ovf = 1'b0;

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 8'(i), 1'b0, 5'(i + 1), (i == 15), 1'b0};
        end
        vecs[16] = '{1'b1, 8'hFF, 1'b0, 5'd16, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 8'hFF, 1'b1, 5'd16, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0};

        repeat (3) step();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_tx_send", 32'(bus.tx_send), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h00);

        // Single byte latency and handshake.
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA5;
        step();
        bus.wr_en = 1'b0;
        chk("t1_empty", 32'(bus.empty), 32'd0);
        chk("t1_send_early", 32'(bus.tx_send), 32'd0);
        step();
        chk("t1_send", 32'(bus.tx_send), 32'd1);
        chk("t1_data", 32'(bus.tx_data), 32'hA5);
        tip_force = 1'b1;
        step();
        chk("t1_send_drop", 32'(bus.tx_send), 32'd0);
        chk("t1_level", 32'(bus.level), 32'd0);
        tip_force = 1'b0;
        repeat (2) step();

        // Fill while UART busy, overflow, set-wins clear, then clear.
        tip_force = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            bus.wr_en   = vecs[i].wr_en;
            bus.wr_data = vecs[i].data;
            bus.clr_ovf = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_level", i), 32'(bus.level), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vecs[i].full));
            chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vecs[i].lvl == 0));
            chk($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_send", i), 32'(bus.tx_send), 32'd0);
        end
        bus.wr_en = 1'b0;
        bus.clr_ovf = 1'b0;
        r0 = recv_cnt;
        tip_force = 1'b0;
        uart_auto = 1'b1;
        wait_drain(1000);
        chk("t2_recv", 32'(recv_cnt - r0), 32'd16);
        chk("t2_no_ff", 32'(saw_ff), 32'd0);

        // Pointer wrap with 40 bytes through the 10-cycle UART model.
        r0 = recv_cnt;
        for (int i = 0; i < 40; i++) begin
            b = 0;
            bus.wr_en = 1'b0;
            while (bus.full && b < 200) begin
                step();
                b++;
            end
            if (b >= 200) begin
                total++;
                bad++;
                $display("FAIL t4_full_stuck got=%0d exp<200", b);
            end
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(i);
            step();
        end
        bus.wr_en = 1'b0;
        wait_drain(2000);
        chk("t4_recv", 32'(recv_cnt - r0), 32'd40);
        chk("t4_overflow", 32'(bus.overflow), 32'd0);
        uart_auto = 1'b0;

        // Push coincident with pop at level 3.
        tip_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(8'hC0 + i);
            step();
        end
        bus.wr_en = 1'b0;
        step();
        chk("t5_level3", 32'(bus.level), 32'd3);
        r0 = recv_cnt;
        tip_force = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hC3;
        step();
        bus.wr_en = 1'b0;
        chk("t5_level_hold", 32'(bus.level), 32'd3);
        chk("t5_send", 32'(bus.tx_send), 32'd1);
        chk("t5_data", 32'(bus.tx_data), 32'hC0);
        uart_auto = 1'b1;
        wait_drain(1000);
        chk("t5_recv", 32'(recv_cnt - r0), 32'd4);
        uart_auto = 1'b0;

        // Reset while in SEND with TiP high and 5 bytes queued.
        tip_force = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(8'hD0 + i);
            step();
        end
        bus.wr_en = 1'b0;
        chk("t6_level5", 32'(bus.level), 32'd5);
        chk("t6_in_send", 32'(bus.tx_send), 32'd1);
        rst = 1'b1;
        tip_force = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_level", 32'(bus.level), 32'd0);
        chk("t6_rst_send", 32'(bus.tx_send), 32'd0);
        chk("t6_rst_empty", 32'(bus.empty), 32'd1);
        repeat (5) step();
        chk("t6_tip_high_idle", 32'(bus.tx_send), 32'd0);
        tip_force = 1'b0;
        repeat (5) step();
        chk("t6_no_byte_idle", 32'(bus.tx_send), 32'd0);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h5A;
        step();
        bus.wr_en = 1'b0;
        b = 0;
        while (!bus.tx_send && b < 10) begin
            step();
            b++;
        end
        chk("t6_resend", 32'(bus.tx_send), 32'd1);
        chk("t6_resend_data", 32'(bus.tx_data), 32'h5A);
        tip_force = 1'b1;
        step();
        tip_force = 1'b0;
        repeat (3) step();
        chk("t6_final_level", 32'(bus.level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
